// File: rtl/pla_sweep_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pla_sweep_driver_pkg
// Description : Shared types and default constants for the PLA sweep harness.
// Revision    : 1.0
// ============================================================================
package pla_sweep_driver_pkg;

    localparam int          c_N_IN     = 15;
    localparam int          c_SIG_W    = 16;
    localparam logic [15:0] c_DEF_POLY = 16'hB400;
    localparam logic [15:0] c_DEF_SEED = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pla_misr.sv
`default_nettype none
// ============================================================================
// Module      : pla_misr
// Description : Galois multiple-input signature register, one bit per cycle.
// Revision    : 1.0
// ============================================================================
module pla_misr
    import pla_sweep_driver_pkg::*;
#(
    parameter int               SIG_W = c_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = c_DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = c_DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [SIG_W-1:0] i_seed,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic             w_fb;

    assign w_fb  = r_sig[0] ^ i_bit;
    assign o_sig = r_sig;

    // Load takes priority so a new sweep always starts from a clean seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= i_seed;
        end else if (i_en) begin
            r_sig <= (r_sig >> 1) ^ (w_fb ? POLY : '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pla_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : pla_sweep_driver
// Description : Sweeps an inclusive input range through a PLA and compacts y0.
// Revision    : 1.0
// ============================================================================
module pla_sweep_driver
    import pla_sweep_driver_pkg::*;
#(
    parameter int               N_IN  = c_N_IN,
    parameter int               SIG_W = c_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = c_DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = c_DEF_SEED,
    parameter int               PIPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_IN-1:0]   lo_vec,
    input  logic [N_IN-1:0]   hi_vec,
    output logic [N_IN-1:0]   x_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     onset_count,
    output logic [N_IN-1:0]   first_on_vec,
    output logic              first_on_valid,
    output logic [SIG_W-1:0]  signature
);

    state_t            r_state;
    logic [N_IN-1:0]   r_x_out;
    logic [N_IN-1:0]   r_hi;
    logic              r_busy;
    logic              r_done;
    logic [N_IN:0]     r_onset_count;
    logic [N_IN-1:0]   r_first_on_vec;
    logic              r_first_on_valid;

    logic              w_accept;
    logic              w_issue;
    logic              w_cons_valid;
    logic [N_IN-1:0]   w_cons_vec;
    logic              w_pipe_busy;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_issue  = (r_state == S_RUN) && !abort;

    // Each issued vector travels alongside its response so compaction can
    // attribute y_in to the vector that produced it.
    generate
        if (PIPE == 0) begin : g_no_pipe
            assign w_cons_valid = w_issue;
            assign w_cons_vec   = r_x_out;
            assign w_pipe_busy  = 1'b0;
        end else begin : g_tag_pipe
            logic [PIPE-1:0]            r_tag_valid;
            logic [PIPE-1:0][N_IN-1:0]  r_tag_vec;
            logic [PIPE:0]              w_valid_shift;
            logic [PIPE:0][N_IN-1:0]    w_vec_shift;

            assign w_valid_shift = {r_tag_valid, w_issue};
            assign w_vec_shift   = {r_tag_vec, r_x_out};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_valid <= '0;
                    r_tag_vec   <= '0;
                end else begin
                    r_tag_valid <= w_valid_shift[PIPE-1:0];
                    r_tag_vec   <= w_vec_shift[PIPE-1:0];
                end
            end

            assign w_cons_valid = r_tag_valid[PIPE-1];
            assign w_cons_vec   = r_tag_vec[PIPE-1];
            assign w_pipe_busy  = |r_tag_valid;
        end
    endgenerate

    // Sequencer: hi is compared before incrementing so an all-ones bound
    // terminates without wrapping x_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x_out <= '0;
            r_hi    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hi <= hi_vec;
                        if (lo_vec > hi_vec) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_x_out <= lo_vec;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort || (r_x_out == r_hi)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_x_out <= r_x_out + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onset_count    <= '0;
            r_first_on_vec   <= '0;
            r_first_on_valid <= 1'b0;
        end else if (w_accept) begin
            r_onset_count    <= '0;
            r_first_on_valid <= 1'b0;
        end else if (w_cons_valid) begin
            r_onset_count <= r_onset_count + {{N_IN{1'b0}}, y_in};
            if (y_in && !r_first_on_valid) begin
                r_first_on_vec   <= w_cons_vec;
                r_first_on_valid <= 1'b1;
            end
        end
    end

    pla_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_seed (SEED),
        .i_en   (w_cons_valid),
        .i_bit  (y_in),
        .o_sig  (signature)
    );

    assign x_out          = r_x_out;
    assign busy           = r_busy;
    assign done           = r_done;
    assign onset_count    = r_onset_count;
    assign first_on_vec   = r_first_on_vec;
    assign first_on_valid = r_first_on_valid;

endmodule
`default_nettype wire

// File: tb/tb_pla_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pla_sweep_driver
// Description : Scoreboard bench for PIPE=0 and PIPE=2 sweep driver instances.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pla_sweep_driver;

    localparam int          c_NI   = 15;
    localparam logic [15:0] c_POLY = 16'hB400;
    localparam logic [15:0] c_SEED = 16'h0000;

    typedef struct {
        int              t0;
        int              lat;
        int              busy_cyc;
        logic [c_NI:0]   cnt;
        logic [c_NI-1:0] fvec;
        logic            fval;
        logic [15:0]     sig;
        logic            chk_x;
        logic [c_NI-1:0] xfin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start_a [2];
    logic            abort_a [2];
    logic            y_a     [2];
    logic            busy_a  [2];
    logic            done_a  [2];
    logic            fval_a  [2];
    logic [c_NI-1:0] lo_a    [2];
    logic [c_NI-1:0] hi_a    [2];
    logic [c_NI-1:0] x_a     [2];
    logic [c_NI-1:0] fvec_a  [2];
    logic [c_NI:0]   cnt_a   [2];
    logic [15:0]     sig_a   [2];
    int              mode_a  [2];
    logic [c_NI-1:0] key_a   [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the PLA netlist: constant, parity of x0, or a small SOP.
    function automatic logic yfun(input int mode, input logic [c_NI-1:0] key,
                                  input logic [c_NI-1:0] v);
        case (mode)
            0:       return 1'b1;
            1:       return v[0];
            default: return (v[0] & v[4] & ~v[7]) | (v[2] & v[11]) | (^(v & key));
        endcase
    endfunction

    assign y_a[0] = yfun(mode_a[0], key_a[0], x_a[0]);

    logic y_d1, y_d2;
    always @(posedge clk) begin
        y_d1 <= yfun(mode_a[1], key_a[1], x_a[1]);
        y_d2 <= y_d1;
    end
    assign y_a[1] = y_d2;

    pla_sweep_driver #(.N_IN(c_NI), .SIG_W(16), .POLY(c_POLY), .SEED(c_SEED), .PIPE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]),
        .lo_vec(lo_a[0]), .hi_vec(hi_a[0]), .x_out(x_a[0]), .y_in(y_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .onset_count(cnt_a[0]),
        .first_on_vec(fvec_a[0]), .first_on_valid(fval_a[0]), .signature(sig_a[0])
    );

    pla_sweep_driver #(.N_IN(c_NI), .SIG_W(16), .POLY(c_POLY), .SEED(c_SEED), .PIPE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]),
        .lo_vec(lo_a[1]), .hi_vec(hi_a[1]), .x_out(x_a[1]), .y_in(y_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .onset_count(cnt_a[1]),
        .first_on_vec(fvec_a[1]), .first_on_valid(fval_a[1]), .signature(sig_a[1])
    );

    // Reference: list the vectors the sweep covers, fold responses, and
    // derive timing from when the last tag leaves the response pipe.
    function automatic exp_t model(input int pipe, input int mode, input logic [c_NI-1:0] key,
                                   input int lo, input int hi, input int abort_k);
        exp_t e;
        int total, n, last_run, drain_exit;
        logic y;
        logic fb;
        e.t0 = 0; e.cnt = '0; e.fval = 1'b0; e.fvec = '0; e.sig = c_SEED;
        if (lo > hi) begin
            e.lat = 1; e.busy_cyc = 0; e.chk_x = 1'b0; e.xfin = '0;
            return e;
        end
        total = hi - lo + 1;
        if (abort_k >= 1 && abort_k <= total) begin
            n = abort_k - 1; last_run = abort_k;
        end else begin
            n = total; last_run = total;
        end
        e.chk_x = 1'b1;
        e.xfin  = 15'(lo + last_run - 1);
        for (int i = 0; i < n; i++) begin
            y = yfun(mode, key, 15'(lo + i));
            e.cnt = e.cnt + 16'(y);
            if (y && !e.fval) begin
                e.fval = 1'b1;
                e.fvec = 15'(lo + i);
            end
            fb    = e.sig[0] ^ y;
            e.sig = (e.sig >> 1) ^ (fb ? c_POLY : 16'h0000);
        end
        drain_exit = last_run + 1;
        if (n > 0 && n + pipe + 1 > drain_exit) drain_exit = n + pipe + 1;
        e.lat      = drain_exit + 1;
        e.busy_cyc = e.lat - 1;
        return e;
    endfunction

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input int p);
        chk($sformatf("rst_x[%0d]", p),     32'(x_a[p]),    32'h0);
        chk($sformatf("rst_busy[%0d]", p),  32'(busy_a[p]), 32'h0);
        chk($sformatf("rst_done[%0d]", p),  32'(done_a[p]), 32'h0);
        chk($sformatf("rst_cnt[%0d]", p),   32'(cnt_a[p]),  32'h0);
        chk($sformatf("rst_fvec[%0d]", p),  32'(fvec_a[p]), 32'h0);
        chk($sformatf("rst_fval[%0d]", p),  32'(fval_a[p]), 32'h0);
        chk($sformatf("rst_sig[%0d]", p),   32'(sig_a[p]),  32'(c_SEED));
    endtask

    task automatic monitor(input int p);
        int   bc;
        exp_t e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0;
            end else if (done_a[p]) begin
                if (qsize(p) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done[%0d]: got done=1 required no done", p);
                end else begin
                    if (p == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("latency[%0d]", p),   32'(cyc - e.t0),  32'(e.lat));
                    chk($sformatf("busy_cyc[%0d]", p),  32'(bc),          32'(e.busy_cyc));
                    chk($sformatf("busy_at_done[%0d]", p), 32'(busy_a[p]), 32'h0);
                    chk($sformatf("count[%0d]", p),     32'(cnt_a[p]),    32'(e.cnt));
                    chk($sformatf("first_valid[%0d]", p), 32'(fval_a[p]), 32'(e.fval));
                    if (e.fval) chk($sformatf("first_vec[%0d]", p), 32'(fvec_a[p]), 32'(e.fvec));
                    chk($sformatf("signature[%0d]", p), 32'(sig_a[p]),    32'(e.sig));
                    if (e.chk_x) chk($sformatf("x_final[%0d]", p), 32'(x_a[p]), 32'(e.xfin));
                end
                bc = 0;
            end else if (busy_a[p]) begin
                bc++;
            end
        end
    endtask

    task automatic run(input int p, input int lo, input int hi, input int mode,
                       input logic [c_NI-1:0] key, input int abort_k, input bit dbl);
        exp_t e;
        int   c;
        int   limit;
        @(negedge clk);
        mode_a[p]  = mode;
        key_a[p]   = key;
        lo_a[p]    = 15'(lo);
        hi_a[p]    = 15'(hi);
        start_a[p] = 1'b1;
        e    = model((p == 0) ? 0 : 2, mode, key, lo, hi, abort_k);
        e.t0 = cyc;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        limit = e.lat + 20;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            start_a[p] = dbl && (c == 3);
            if (start_a[p]) begin
                lo_a[p] = 15'($urandom);
                hi_a[p] = 15'($urandom);
            end
            abort_a[p] = (abort_k != 0) && (c == abort_k);
        end while (qsize(p) != 0 && c < limit);
        start_a[p] = 1'b0;
        abort_a[p] = 1'b0;
        checks++;
        if (qsize(p) != 0) begin
            errors++;
            $display("FAIL done_timeout[%0d]: got no done after %0d cycles required done", p, limit);
            if (p == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int lo, hi, r, p, ak, len;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0; abort_a[i] = 1'b0; lo_a[i] = '0; hi_a[i] = '0;
            mode_a[i]  = 0;    key_a[i]   = '0;
        end
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;

        fork
            monitor(0);
            monitor(1);
        join_none

        run(0, 5, 5, 0, '0, 0, 1'b0);
        chk("tp1_count", 32'(cnt_a[0]), 32'd1);
        chk("tp1_first", 32'(fvec_a[0]), 32'd5);
        chk("tp1_sig",   32'(sig_a[0]), 32'hB400);

        run(0, 0, 7, 1, '0, 0, 1'b0);
        chk("tp2_count", 32'(cnt_a[0]), 32'd4);
        chk("tp2_first", 32'(fvec_a[0]), 32'd1);

        run(1, 15'h7FFE, 15'h7FFF, 0, '0, 0, 1'b0);
        chk("tp3_x",     32'(x_a[1]), 32'h7FFF);
        chk("tp3_count", 32'(cnt_a[1]), 32'd2);

        run(0, 10, 3, 2, 15'h1234, 0, 1'b0);
        chk("tp4_count", 32'(cnt_a[0]), 32'd0);
        chk("tp4_sig",   32'(sig_a[0]), 32'(c_SEED));
        chk("tp4_fval",  32'(fval_a[0]), 32'd0);
        run(1, 10, 3, 2, 15'h1234, 0, 1'b0);

        run(0, 0, 15'h7FFF, 2, 15'h2C6B, 100, 1'b1);
        chk("tp5_count_le99", 32'(cnt_a[0] <= 16'd99), 32'd1);
        run(1, 0, 15'h7FFF, 2, 15'h51A7, 100, 1'b1);

        for (int i = 0; i < 24; i++) begin
            p  = $urandom_range(0, 1);
            lo = $urandom_range(0, 32767);
            r  = $urandom_range(0, 9);
            if (r == 0 && lo > 0) begin
                hi = $urandom_range(0, lo - 1);
            end else if (r == 1) begin
                lo = 32767 - $urandom_range(0, 5);
                hi = 32767;
            end else begin
                hi = lo + $urandom_range(0, 40);
                if (hi > 32767) hi = 32767;
            end
            len = (lo <= hi) ? hi - lo + 1 : 1;
            ak  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : 0;
            run(p, lo, hi, $urandom_range(0, 2), 15'($urandom), ak, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a sweep: no result, no done pulse.
        @(negedge clk);
        mode_a[0] = 2; key_a[0] = 15'h0F0F; lo_a[0] = 15'd0; hi_a[0] = 15'd300;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_busy", 32'(busy_a[0]), 32'h0);
        run(0, 20, 60, 2, 15'h3A5C, 0, 1'b0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pla_sweep_driver.md
Name: pla_sweep_driver

Overview:
- Sequential harness that sits on both sides of a synthesised single-output PLA function block (x0..x14 -> y0).
- Upstream: walks an inclusive input-vector range and drives the function inputs from a register.
- Downstream: compacts the returned y0 stream into an onset count, a first-onset vector and a MISR signature.
- Used for on-chip equivalence checks between original and optimised netlists of the same function.

Parameters:
- N_IN, 15, width of the function input vector.
- SIG_W, 16, signature register width.
- POLY, 16'hB400, Galois MISR feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'h0000, signature value loaded at start.
- PIPE, 0, register stages between x_out and y_in (0..3).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; begins a sweep when idle.
- abort  in  1  ends the sweep early; partial results are kept.
- lo_vec  in  N_IN  first vector, inclusive; sampled on accepted start.
- hi_vec  in  N_IN  last vector, inclusive; sampled on accepted start.
- x_out  out  N_IN  registered function inputs (drive x0..x14, LSB=x0).
- y_in  in  1  function output y0, valid PIPE cycles after x_out.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are final.
- onset_count  out  N_IN+1  number of vectors with y_in=1.
- first_on_vec  out  N_IN  lowest vector in the sweep with y_in=1.
- first_on_valid  out  1  first_on_vec holds a real vector.
- signature  out  SIG_W  MISR over the y_in stream.

Behaviour:
- Reset is asynchronous and active-high. All of the following are 0: state (IDLE), x_out, busy, done, onset_count, first_on_vec, first_on_valid, tag pipe. signature resets to SEED.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE + start: latch lo/hi. Clear count and first_on_valid; signature <= SEED.
  - If lo_vec > hi_vec (unsigned): go to DONE (empty sweep).
  - Otherwise: x_out <= lo_vec, go to RUN.
- RUN:
  - Each cycle presents one vector and pushes a valid tag, carrying the vector, into a PIPE-deep shift register. PIPE=0 means the tag is consumed in the same cycle.
  - If x_out == hi: no increment, go to DRAIN. The comparison happens before the increment, so hi = all-ones never wraps.
  - Otherwise: x_out <= x_out+1.
- DRAIN: wait until the tag pipe is empty, then go to DONE. With PIPE=0, DRAIN lasts exactly 1 cycle.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy drops in the same cycle done rises.
- Result hold: results stay until the next accepted start. x_out holds its last vector.
- Compaction, on every consumed valid tag with response y:
  - onset_count += y. The count cannot overflow: max 2^N_IN.
  - If y=1 and !first_on_valid: first_on_vec <= tag vector, first_on_valid <= 1.
  - MISR: fb = sig[0]^y; sig <= (sig>>1) ^ (fb ? POLY : 0).
- abort in RUN: stop issuing vectors and go to DRAIN. Tags already in flight are still consumed.
- abort in other states: ignored.
- start while busy or in DONE: ignored.
- Simultaneous start and abort in IDLE: start wins; abort is ignored.
- Total latency: start -> done = (hi-lo+1) + PIPE + 2 cycles. For an empty sweep it is 1 cycle.
- Reset mid-sweep returns immediately to reset values. There is no done pulse.

Decomposition:
- Shared package holds:
  - State enum (IDLE/RUN/DRAIN/DONE).
  - Default POLY and SEED constants.
  - Function-width constant N_IN=15.
- One sub-module, pla_misr: a SIG_W Galois MISR with inputs load/seed/en/bit. It is reused by the two-netlist comparator stage.

Test Plan:
- PIPE=0, lo=5, hi=5, stub y=1 -> onset_count=1, first_on_vec=5, first_on_valid=1, signature=16'hB400, done 3 cycles after start.
- PIPE=0, lo=0, hi=7, stub y=x_out[0] -> onset_count=4, first_on_vec=1. signature equals the reference model's MISR of the bit stream 0,1,0,1,0,1,0,1. busy high for 8 RUN + 1 DRAIN cycles.
- PIPE=2, lo=0x7FFE, hi=0x7FFF, stub y=1 -> x_out ends at 0x7FFF with no wrap, onset_count=2, done at cycle 6.
- lo=10, hi=3 -> done one cycle after start, onset_count=0, signature=SEED, first_on_valid=0.
- lo=0, hi=0x7FFF with the real y0 netlist, abort asserted at cycle 100 -> exactly 99 vectors compacted. A second start during busy is ignored.
- Assert rst mid-RUN -> outputs immediately return to reset values with no done pulse. A new start then sweeps correctly.
